// File: rtl/xoroshiro_lanes_pkg.sv
// Shared definitions for the multi-lane xoroshiro128 generator: lane width,
// scrambler encodings, per-mode rotation amounts, zero-seed guard and FSM states.
package xoroshiro_lanes_pkg;

  localparam int LANE_W        = 64;
  localparam int MODE_PLUS     = 0;
  localparam int MODE_STARSTAR = 1;

  localparam logic [LANE_W-1:0] ZERO_GUARD = 64'h9E3779B97F4A7C15;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARM     = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  function automatic int rot_a(input int mode);
    return (mode == MODE_STARSTAR) ? 24 : 55;
  endfunction

  function automatic int rot_b(input int mode);
    return (mode == MODE_STARSTAR) ? 16 : 14;
  endfunction

  function automatic int rot_c(input int mode);
    return (mode == MODE_STARSTAR) ? 37 : 36;
  endfunction

  // Callers pass constant amounts in 1..63, so this reduces to wiring.
  function automatic logic [LANE_W-1:0] rotl64(input logic [LANE_W-1:0] x, input int r);
    return (x << r) | (x >> (LANE_W - r));
  endfunction

endpackage

// File: rtl/xoroshiro_lanes_if.sv
// Seed/output handshake bundle between the generator and its consumer.
interface xoroshiro_lanes_if #(
  parameter int NUM_LANES = 4
);
  localparam int W = NUM_LANES * 64;

  logic         seed_load;
  logic [W-1:0] seed0;
  logic [W-1:0] seed1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  modport master (
    output seed_load, seed0, seed1, out_ready,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  seed_load, seed0, seed1, out_ready,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/xoroshiro_lanes_lane.sv
// One independent xoroshiro128 lane: seed load with zero guard, state step,
// and the scrambled result taken from the lane registers only.
module xoroshiro_lanes_lane
  import xoroshiro_lanes_pkg::*;
#(
  parameter int MODE     = MODE_PLUS,
  parameter int LANE_IDX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LANE_W-1:0] seed0,
  input  logic [LANE_W-1:0] seed1,
  output logic [LANE_W-1:0] result
);

  localparam int ROT_A = rot_a(MODE);
  localparam int ROT_B = rot_b(MODE);
  localparam int ROT_C = rot_c(MODE);

  logic [LANE_W-1:0] s0_q, s0_d;
  logic [LANE_W-1:0] s1_q, s1_d;
  logic [LANE_W-1:0] t;

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    t    = s0_q ^ s1_q;
    if (load) begin
      // An all-zero state would lock the generator at zero forever.
      if ((seed0 == '0) && (seed1 == '0)) begin
        s0_d = ZERO_GUARD ^ LANE_W'(LANE_IDX);
        s1_d = 64'd1;
      end else begin
        s0_d = seed0;
        s1_d = seed1;
      end
    end else if (step) begin
      s0_d = rotl64(s0_q, ROT_A) ^ t ^ (t << ROT_B);
      s1_d = rotl64(t, ROT_C);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  generate
    if (MODE == MODE_STARSTAR) begin : g_starstar
      logic [LANE_W-1:0] mul5;
      logic [LANE_W-1:0] rot7;
      // x*5 and x*9 as shift-add keeps the scrambler free of real multipliers.
      assign mul5   = (s0_q << 2) + s0_q;
      assign rot7   = rotl64(mul5, 7);
      assign result = (rot7 << 3) + rot7;
    end else begin : g_plus
      assign result = s0_q + s1_q;
    end
  endgenerate

endmodule

// File: rtl/xoroshiro_lanes.sv
// NUM_LANES-wide xoroshiro128 generator: shared seed/warm-up/run FSM driving
// independent lanes, with a valid/ready output that steps only on transfer.
module xoroshiro_lanes
  import xoroshiro_lanes_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int MODE      = MODE_PLUS,
  parameter int WARMUP    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  xoroshiro_lanes_if.slave  bus
);

  localparam int         W         = NUM_LANES * LANE_W;
  localparam logic [7:0] WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lane_load;
  logic       lane_step;
  logic [W-1:0] lane_result;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_load = bus.seed_load;
    lane_step = 1'b0;
    // A reload wins over a simultaneous transfer; that transfer is dropped.
    if (bus.seed_load) begin
      cnt_d   = 8'd0;
      state_d = (WARMUP > 0) ? ST_WARM : ST_RUN;
    end else begin
      case (state_q)
        ST_WARM: begin
          lane_step = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == WARM_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          lane_step = bus.out_ready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNSEEDED;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      xoroshiro_lanes_lane #(
        .MODE     (MODE),
        .LANE_IDX (i)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (lane_load),
        .step   (lane_step),
        .seed0  (bus.seed0[LANE_W*i +: LANE_W]),
        .seed1  (bus.seed1[LANE_W*i +: LANE_W]),
        .result (lane_result[LANE_W*i +: LANE_W])
      );
    end
  endgenerate

  // Outputs depend on registered state only, so reset clears them at once.
  assign bus.out_valid = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_WARM);
  assign bus.out_data  = (state_q == ST_RUN) ? lane_result : '0;

endmodule

// File: tb/tb_xoroshiro_lanes.sv
// Directed bench for xoroshiro_lanes: three instances (plus, starstar, plus
// with two warm-up steps) driven by one linear stimulus sequence.
module tb_xoroshiro_lanes;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xoroshiro_lanes_if #(.NUM_LANES(4)) if0 ();
  xoroshiro_lanes_if #(.NUM_LANES(4)) if1 ();
  xoroshiro_lanes_if #(.NUM_LANES(4)) if2 ();

  xoroshiro_lanes #(.NUM_LANES(4), .MODE(0), .WARMUP(0)) dut_plus (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  xoroshiro_lanes #(.NUM_LANES(4), .MODE(1), .WARMUP(0)) dut_ss (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  xoroshiro_lanes #(.NUM_LANES(4), .MODE(0), .WARMUP(2)) dut_warm (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  // lane3 = 1/2, lane2 = 0/0 (guarded), lane1 arbitrary, lane0 = 1/2
  localparam logic [255:0] SEED0 = {64'h1, 64'h0, 64'hDEADBEEF, 64'h1};
  localparam logic [255:0] SEED1 = {64'h2, 64'h0, 64'h12345,    64'h2};

  localparam logic [63:0] PLUS_1 = 64'h0000000000000003;
  localparam logic [63:0] PLUS_2 = 64'h008000300000C003;
  localparam logic [63:0] PLUS_3 = 64'h0118406038000363;
  localparam logic [63:0] SS_1   = 64'h0000000000001680;
  localparam logic [63:0] GUARD2 = 64'h9E3779B97F4A7C18;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic rdy);
    if0.seed_load = ld;  if1.seed_load = ld;  if2.seed_load = ld;
    if0.out_ready = rdy; if1.out_ready = rdy; if2.out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if0.seed0 = SEED0; if1.seed0 = SEED0; if2.seed0 = SEED0;
    if0.seed1 = SEED1; if1.seed1 = SEED1; if2.seed1 = SEED1;
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();

    chk1("reset_valid", if0.out_valid, 1'b0);
    chk1("reset_busy", if2.busy, 1'b0);
    chk("reset_data", if0.out_data[63:0], 64'h0);

    rst_n = 1'b1;
    drive(1'b0, 1'b1);
    tick();
    tick();
    chk1("unseeded_valid", if0.out_valid, 1'b0);
    chk("unseeded_data", if0.out_data[63:0], 64'h0);

    // seed with consumer ready
    drive(1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1);
    chk1("plus_valid_k1", if0.out_valid, 1'b1);
    chk("plus_lane0_first", if0.out_data[63:0], PLUS_1);
    chk("plus_lane3_same_seed", if0.out_data[255:192], PLUS_1);
    chk("plus_lane2_zero_guard", if0.out_data[191:128], GUARD2);
    chk("ss_lane0_first", if1.out_data[63:0], SS_1);
    chk1("warm_busy_c1", if2.busy, 1'b1);
    chk1("warm_valid_c1", if2.out_valid, 1'b0);

    tick();
    chk("plus_lane0_second", if0.out_data[63:0], PLUS_2);
    chk1("warm_busy_c2", if2.busy, 1'b1);
    chk1("warm_valid_c2", if2.out_valid, 1'b0);

    tick();
    chk1("warm_busy_done", if2.busy, 1'b0);
    chk1("warm_valid_done", if2.out_valid, 1'b1);
    chk("warm_lane0_first", if2.out_data[63:0], PLUS_3);

    // reseed and stall the consumer
    drive(1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk1("stall_valid", if0.out_valid, 1'b1);
      chk("stall_lane0_hold", if0.out_data[63:0], PLUS_1);
      tick();
    end
    drive(1'b0, 1'b1);
    tick();
    chk("stall_release", if0.out_data[63:0], PLUS_2);

    // reload coincident with a transfer: reload wins, no step
    drive(1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1);
    chk1("reload_valid", if0.out_valid, 1'b1);
    chk("reload_lane0", if0.out_data[63:0], PLUS_1);
    chk("reload_lane2", if0.out_data[191:128], GUARD2);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", if0.out_valid, 1'b0);
    chk("async_rst_lane0", if0.out_data[63:0], 64'h0);
    chk("async_rst_lane2", if0.out_data[191:128], 64'h0);
    chk1("async_rst_ss_valid", if1.out_valid, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk1("post_rst_unseeded", if0.out_valid, 1'b0);
    chk("post_rst_data", if0.out_data[63:0], 64'h0);

    drive(1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0);
    chk1("reseed_valid", if0.out_valid, 1'b1);
    chk("reseed_lane0", if0.out_data[63:0], PLUS_1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
